// File: rtl/pw_pkg.sv
// pw_pkg: shared constants for the USB pattern matcher (FSM encoding, stretch length, lane width).
package pw_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRE  = 2'd2;
    localparam int MATCH_STRETCH_CYCLES = 4;
    localparam int LANE_W = 8;
endpackage

// File: rtl/pw_masked_compare.sv
// pw_masked_compare: per-lane masked byte compare; lanes at or beyond the effective length are don't care.
module pw_masked_compare
    import pw_pkg::*;
#(
    parameter int pBYTES       = 64,
    parameter int pCOUNT_WIDTH = 7
) (
    input  logic [pBYTES*LANE_W-1:0] i_window,
    input  logic [pBYTES*LANE_W-1:0] i_pattern,
    input  logic [pBYTES*LANE_W-1:0] i_mask,
    input  logic [pCOUNT_WIDTH-1:0]  i_len,
    output logic                     o_hit
);
    logic [pBYTES-1:0] w_lane_ok;

    for (genvar i = 0; i < pBYTES; i++) begin : g_lane
        assign w_lane_ok[i] = (i_len <= pCOUNT_WIDTH'(i)) ||
            (((i_window[i*LANE_W +: LANE_W] ^ i_pattern[i*LANE_W +: LANE_W]) & i_mask[i*LANE_W +: LANE_W]) == '0);
    end

    assign o_hit = &w_lane_ok;
endmodule

// File: rtl/pw_pattern_matcher.sv
// pw_pattern_matcher: sliding-window masked pattern matcher driving the trigger generator's match input.
// Optional PW_MATCH_STRETCH_EN holds O_match high for MATCH_STRETCH_CYCLES cycles instead of one.
module pw_pattern_matcher
    import pw_pkg::*;
#(
    parameter int pBYTES       = 64,
    parameter int pCOUNT_WIDTH = 7
) (
    input  logic                     usb_clk,
    input  logic                     reset_i,
    input  logic [7:0]               I_data,
    input  logic                     I_data_valid,
    input  logic [pBYTES*8-1:0]      I_pattern,
    input  logic [pBYTES*8-1:0]      I_mask,
    input  logic [pCOUNT_WIDTH-1:0]  I_pattern_bytes,
    input  logic                     I_arm,
    input  logic                     I_disarm,
    output logic                     O_armed,
    output logic                     O_match
);
    localparam logic [pCOUNT_WIDTH-1:0] MAXC = pCOUNT_WIDTH'(pBYTES);

    logic [pBYTES*LANE_W-1:0] r_window;
    logic [pCOUNT_WIDTH-1:0]  r_count;
    logic [pCOUNT_WIDTH-1:0]  w_len;
    logic [1:0]               r_state;
    logic                     r_new_byte;
    logic                     r_match;
    logic                     w_cmp;
    logic                     w_hit;
    logic                     w_arm;
`ifdef PW_MATCH_STRETCH_EN
    logic [1:0]               r_stretch;
`endif

    assign w_len   = (I_pattern_bytes > MAXC) ? MAXC : I_pattern_bytes;
    assign w_arm   = (r_state == ST_IDLE) && I_arm && !I_disarm;
    // Only compare right after a new byte so a static window cannot re-fire
    assign w_hit   = r_new_byte && (w_len != '0) && (r_count >= w_len) && w_cmp;
    assign O_armed = (r_state == ST_ARMED);
    assign O_match = r_match;

    pw_masked_compare #(.pBYTES(pBYTES), .pCOUNT_WIDTH(pCOUNT_WIDTH)) u_cmp (
        .i_window  (r_window),
        .i_pattern (I_pattern),
        .i_mask    (I_mask),
        .i_len     (w_len),
        .o_hit     (w_cmp)
    );

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            r_window   <= '0;
            r_count    <= '0;
            r_new_byte <= 1'b0;
        end else begin
            r_new_byte <= I_data_valid;
            if (I_data_valid)
                r_window <= {r_window[pBYTES*LANE_W-LANE_W-1:0], I_data};
            // Arming restarts the count so a match needs bytes received after arming
            if (w_arm)
                r_count <= '0;
            else if (I_data_valid && r_count != MAXC)
                r_count <= r_count + pCOUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge usb_clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_match <= 1'b0;
`ifdef PW_MATCH_STRETCH_EN
            r_stretch <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: if (w_arm) r_state <= ST_ARMED;
                ST_ARMED: begin
                    if (I_disarm) begin
                        r_state <= ST_IDLE;
                    end else if (w_hit) begin
                        r_state <= ST_FIRE;
                        r_match <= 1'b1;
`ifdef PW_MATCH_STRETCH_EN
                        r_stretch <= '0;
`endif
                    end
                end
                ST_FIRE: begin
`ifdef PW_MATCH_STRETCH_EN
                    if (r_stretch == 2'(MATCH_STRETCH_CYCLES - 1)) begin
                        r_match <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_stretch <= r_stretch + 2'd1;
                    end
`else
                    r_match <= 1'b0;
                    r_state <= ST_IDLE;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_match <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pw_pattern_matcher.sv
// tb_pw_pattern_matcher: scoreboard bench for the masked pattern matcher (default and stretch builds).
module tb_pw_pattern_matcher;
    localparam int NB = 64;
    localparam int CW = 7;
`ifdef PW_MATCH_STRETCH_EN
    localparam int S = 4;
`else
    localparam int S = 1;
`endif

    logic            usb_clk = 1'b0;
    logic            reset_i = 1'b1;
    logic [7:0]      I_data = '0;
    logic            I_data_valid = 1'b0;
    logic [NB*8-1:0] I_pattern = '0;
    logic [NB*8-1:0] I_mask = '0;
    logic [CW-1:0]   I_pattern_bytes = '0;
    logic            I_arm = 1'b0;
    logic            I_disarm = 1'b0;
    logic            O_armed;
    logic            O_match;

    int   total = 0;
    int   bad = 0;
    logic q[$];
    logic exp_armed = 1'b0;
    logic [7:0] pb [NB];

    always #5 usb_clk = ~usb_clk;

    pw_pattern_matcher #(.pBYTES(NB), .pCOUNT_WIDTH(CW)) dut (
        .usb_clk         (usb_clk),
        .reset_i         (reset_i),
        .I_data          (I_data),
        .I_data_valid    (I_data_valid),
        .I_pattern       (I_pattern),
        .I_mask          (I_mask),
        .I_pattern_bytes (I_pattern_bytes),
        .I_arm           (I_arm),
        .I_disarm        (I_disarm),
        .O_armed         (O_armed),
        .O_match         (O_match)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_byte(input int i, input logic [7:0] p, input logic [7:0] m);
        I_pattern[i*8 +: 8] = p;
        I_mask[i*8 +: 8] = m;
    endtask

    task automatic arm(input logic a, input logic d);
        @(negedge usb_clk);
        I_arm = a;
        I_disarm = d;
        @(negedge usb_clk);
        I_arm = 1'b0;
        I_disarm = 1'b0;
        if (d) exp_armed = 1'b0;
        else if (a) exp_armed = 1'b1;
        chk("armed", O_armed, exp_armed);
    endtask

    // hit: this byte completes the pattern; dis: assert disarm on the hit-evaluation cycle
    task automatic send(input logic [7:0] b, input logic hit, input logic dis);
        logic e;
        e = hit && exp_armed && !dis;
        @(negedge usb_clk);
        I_data = b;
        I_data_valid = 1'b1;
        for (int c = 0; c < S; c++) q.push_back(e);
        q.push_back(1'b0);
        @(negedge usb_clk);
        I_data_valid = 1'b0;
        I_disarm = dis;
        for (int c = 0; c <= S; c++) begin
            @(posedge usb_clk);
            #1;
            I_disarm = 1'b0;
            chk("match", O_match, q.pop_front());
        end
        if (e || dis) exp_armed = 1'b0;
        chk("armed_after", O_armed, exp_armed);
    endtask

    task automatic seq3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic hit);
        send(a, 1'b0, 1'b0);
        send(b, 1'b0, 1'b0);
        send(c, hit, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge usb_clk);
        #1;
        chk("rst_armed", O_armed, 0);
        chk("rst_match", O_match, 0);
        @(negedge usb_clk);
        reset_i = 1'b0;

        I_pattern_bytes = 7'd3;
        for (int i = 0; i < NB; i++) set_byte(i, 8'h00, 8'hFF);
        set_byte(0, 8'h2D, 8'hFF);
        set_byte(1, 8'h00, 8'hFF);
        set_byte(2, 8'h69, 8'hFF);

        arm(1, 0);
        seq3(8'h69, 8'h00, 8'h2D, 1);

        set_byte(1, 8'h00, 8'h00);
        arm(1, 0);
        seq3(8'h69, 8'hAB, 8'h2D, 1);
        arm(1, 0);
        seq3(8'h68, 8'hAB, 8'h2D, 0);
        arm(0, 1);
        set_byte(1, 8'h00, 8'hFF);

        seq3(8'h69, 8'h00, 8'h2D, 0);
        arm(1, 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge usb_clk);
            #1;
            chk("prearm_quiet", O_match, 0);
        end
        seq3(8'h69, 8'h00, 8'h2D, 1);

        arm(1, 1);
        arm(1, 0);
        send(8'h69, 0, 0);
        send(8'h00, 0, 0);
        send(8'h2D, 1, 1);

        arm(1, 0);
        send(8'h69, 0, 0);
        send(8'h00, 0, 0);
        arm(1, 0);
        send(8'h2D, 1, 0);

        I_pattern_bytes = 7'd0;
        arm(1, 0);
        seq3(8'h69, 8'h00, 8'h2D, 0);
        arm(0, 1);

        for (int pass = 0; pass < 2; pass++) begin
            I_pattern_bytes = (pass == 0) ? 7'(NB) : 7'(NB + 5);
            for (int i = 0; i < NB; i++) begin
                pb[i] = 8'($urandom);
                set_byte(i, pb[i], 8'hFF);
            end
            arm(1, 0);
            for (int j = NB - 1; j >= 0; j--) send(pb[j], j == 0, 0);
        end

`ifdef PW_MATCH_STRETCH_EN
        I_pattern_bytes = 7'd3;
        set_byte(0, 8'h2D, 8'hFF);
        set_byte(1, 8'h00, 8'hFF);
        set_byte(2, 8'h69, 8'hFF);
        arm(1, 0);
        send(8'h69, 0, 0);
        send(8'h00, 0, 0);
        @(negedge usb_clk);
        I_data = 8'h2D;
        I_data_valid = 1'b1;
        @(negedge usb_clk);
        I_data_valid = 1'b0;
        @(posedge usb_clk);
        #1;
        chk("stretch_hi", O_match, 1);
        @(posedge usb_clk);
        #3;
        reset_i = 1'b1;
        #1;
        chk("async_rst_match", O_match, 0);
        chk("async_rst_armed", O_armed, 0);
        @(negedge usb_clk);
        reset_i = 1'b0;
        exp_armed = 1'b0;
        arm(1, 0);
        arm(0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
